// File: rtl/mips_rf_write_arbiter_if.sv
// rtl/mips_rf_write_arbiter_if.sv - writeback request bus and register file write port
//
// Purpose: bundles the NREQ writeback requesters' valid/ready/address/data
// signals together with the registered register file write port.
// Signals:
//   req_valid  [NREQ]      requester i has a write pending
//   req_ready  [NREQ]      grant to requester i (one-hot or zero)
//   req_wa     [NREQ*AWL]  write address, requester i at [i*AWL +: AWL]
//   req_wd     [NREQ*DWL]  write data, requester i at [i*DWL +: DWL]
//   rf_wen, rf_wa, rf_wd   register file write port
// Modports: master = requesters / register file side, slave = arbiter.

interface mips_rf_write_arbiter_if #(
    parameter int AWL  = 5,
    parameter int DWL  = 32,
    parameter int NREQ = 3
);
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*AWL-1:0] req_wa;
    logic [NREQ*DWL-1:0] req_wd;
    logic                rf_wen;
    logic [AWL-1:0]      rf_wa;
    logic [DWL-1:0]      rf_wd;

    modport master (
        output req_valid, req_wa, req_wd,
        input  req_ready, rf_wen, rf_wa, rf_wd
    );

    modport slave (
        input  req_valid, req_wa, req_wd,
        output req_ready, rf_wen, rf_wa, rf_wd
    );
endinterface

// File: rtl/mips_rf_write_arbiter.sv
// rtl/mips_rf_write_arbiter.sv - register file write port arbiter with scoreboard
//
// Purpose: shares the single register file write port between NREQ writeback
// sources with a valid/ready arbiter, registers the winning write, and keeps
// a per-register busy scoreboard for operand hazard checks.
// Build option: MIPS_RF_WRITE_ARB_FIXED_PRIO_EN selects fixed priority
// (lowest index wins, no pointer); undefined gives round-robin.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   bus (slave)         requester handshake and register file write port
//   rsv_en, rsv_addr    reserve destination register
//   chk_ra1, chk_ra2    operand addresses to check
//   busy1, busy2, stall operand busy flags and their OR
//   rsv_err             sticky: reservation of an already-busy register

module mips_rf_write_arbiter #(
    parameter int AWL  = 5,
    parameter int DWL  = 32,
    parameter int NREQ = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    mips_rf_write_arbiter_if.slave        bus,
    input  logic                          rsv_en,
    input  logic [AWL-1:0]                rsv_addr,
    input  logic [AWL-1:0]                chk_ra1,
    input  logic [AWL-1:0]                chk_ra2,
    output logic                          busy1,
    output logic                          busy2,
    output logic                          stall,
    output logic                          rsv_err
);
    localparam int NREG = 1 << AWL;
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Unpacked views of the flat request buses
    logic [AWL-1:0] wa_arr [NREQ];
    logic [DWL-1:0] wd_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign wa_arr[g] = bus.req_wa[g*AWL +: AWL];
        assign wd_arr[g] = bus.req_wd[g*DWL +: DWL];
    end

    logic [NREQ-1:0] grant;
    logic            xfer;
    logic [PW-1:0]   gnt_idx;
    logic [AWL-1:0]  sel_wa;
    logic [DWL-1:0]  sel_wd;

    logic            rf_wen_q, rf_wen_d;
    logic [AWL-1:0]  rf_wa_q, rf_wa_d;
    logic [DWL-1:0]  rf_wd_q, rf_wd_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic            rsv_err_q, rsv_err_d;

`ifndef MIPS_RF_WRITE_ARB_FIXED_PRIO_EN
    logic [PW-1:0]   last_q, last_d;
    int              rr_idx;
`endif

    // Arbitration: first valid requester in search order wins
    always_comb begin
        grant   = '0;
        xfer    = 1'b0;
        gnt_idx = '0;
`ifdef MIPS_RF_WRITE_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) begin
            if (!xfer && bus.req_valid[PW'(i)]) begin
                xfer           = 1'b1;
                gnt_idx        = PW'(i);
                grant[PW'(i)]  = 1'b1;
            end
        end
`else
        rr_idx = 0;
        // Search starts just after the last winner and wraps
        for (int off = 1; off <= NREQ; off++) begin
            rr_idx = int'(last_q) + off;
            if (rr_idx >= NREQ) begin
                rr_idx = rr_idx - NREQ;
            end
            if (!xfer && bus.req_valid[rr_idx[PW-1:0]]) begin
                xfer                   = 1'b1;
                gnt_idx                = rr_idx[PW-1:0];
                grant[rr_idx[PW-1:0]]  = 1'b1;
            end
        end
`endif
        sel_wa = wa_arr[gnt_idx];
        sel_wd = wd_arr[gnt_idx];
    end

    // Next-state for write port, pointer and scoreboard
    always_comb begin
        rf_wen_d  = xfer && (sel_wa != '0);
        rf_wa_d   = xfer ? sel_wa : rf_wa_q;
        rf_wd_d   = xfer ? sel_wd : rf_wd_q;
`ifndef MIPS_RF_WRITE_ARB_FIXED_PRIO_EN
        last_d    = xfer ? gnt_idx : last_q;
`endif
        busy_d    = busy_q;
        // Clear first so a same-cycle reservation of the same register wins
        if (rf_wen_d) begin
            busy_d[sel_wa] = 1'b0;
        end
        if (rsv_en && (rsv_addr != '0)) begin
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
        // Double reservation is only an error if the pending write is not retiring now
        rsv_err_d = rsv_err_q
                  | (rsv_en && (rsv_addr != '0) && busy_q[rsv_addr]
                     && !(rf_wen_d && (sel_wa == rsv_addr)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen_q  <= 1'b0;
            rf_wa_q   <= '0;
            rf_wd_q   <= '0;
            busy_q    <= '0;
            rsv_err_q <= 1'b0;
`ifndef MIPS_RF_WRITE_ARB_FIXED_PRIO_EN
            last_q    <= PW'(NREQ - 1);
`endif
        end else begin
            rf_wen_q  <= rf_wen_d;
            rf_wa_q   <= rf_wa_d;
            rf_wd_q   <= rf_wd_d;
            busy_q    <= busy_d;
            rsv_err_q <= rsv_err_d;
`ifndef MIPS_RF_WRITE_ARB_FIXED_PRIO_EN
            last_q    <= last_d;
`endif
        end
    end

    assign bus.req_ready = grant;
    assign bus.rf_wen    = rf_wen_q;
    assign bus.rf_wa     = rf_wa_q;
    assign bus.rf_wd     = rf_wd_q;

    // Lookups see registered state only; register 0 is never busy
    assign busy1   = busy_q[chk_ra1] & (chk_ra1 != '0);
    assign busy2   = busy_q[chk_ra2] & (chk_ra2 != '0);
    assign stall   = busy1 | busy2;
    assign rsv_err = rsv_err_q;

endmodule

// File: tb/tb_mips_rf_write_arbiter.sv
// tb/tb_mips_rf_write_arbiter.sv - directed self-checking bench for mips_rf_write_arbiter

module tb_mips_rf_write_arbiter;
    localparam int AWL  = 5;
    localparam int DWL  = 32;
    localparam int NREQ = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           rsv_en = 1'b0;
    logic [AWL-1:0] rsv_addr = '0;
    logic [AWL-1:0] chk_ra1 = '0;
    logic [AWL-1:0] chk_ra2 = '0;
    logic           busy1, busy2, stall, rsv_err;

    int checks = 0;
    int errors = 0;

    mips_rf_write_arbiter_if #(.AWL(AWL), .DWL(DWL), .NREQ(NREQ)) bus ();

    mips_rf_write_arbiter #(.AWL(AWL), .DWL(DWL), .NREQ(NREQ)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .chk_ra1  (chk_ra1),
        .chk_ra2  (chk_ra2),
        .busy1    (busy1),
        .busy2    (busy2),
        .stall    (stall),
        .rsv_err  (rsv_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs may be changed right after return
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AWL-1:0] wa, input logic [DWL-1:0] wd);
        bus.req_wa[i*AWL +: AWL] = wa;
        bus.req_wd[i*DWL +: DWL] = wd;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_wa    = '0;
        bus.req_wd    = '0;
        step();

        // Build up state so reset has something to clear
        rsv_en = 1'b1; rsv_addr = 5'd3; chk_ra1 = 5'd3;
        step();
        step();                                   // second reserve of 3 -> rsv_err
        rsv_en = 1'b0;
        bus.req_valid = 3'b001; set_req(0, 5'd2, 32'hDEAD);
        step();
        bus.req_valid = '0;
        check("pre_rst_wen", bus.rf_wen, 1);
        check("pre_rst_stall", stall, 1);
        check("pre_rst_err", rsv_err, 1);

        // Mid-cycle reset, no clock edge required
        #2 rst_n = 1'b0;
        #1;
        check("rst_wen", bus.rf_wen, 0);
        check("rst_stall", stall, 0);
        check("rst_err", rsv_err, 0);
        check("rst_wa", bus.rf_wa, 0);
        check("rst_wd", bus.rf_wd, 0);
        step();
        rst_n = 1'b1;
        step();

        // Contention: all three valid
        bus.req_valid = 3'b111;
        set_req(0, 5'd5, 32'hA); set_req(1, 5'd6, 32'hB); set_req(2, 5'd7, 32'hC);
        #1;
        check("cont_rdy0", bus.req_ready, 3'b001);
`ifdef MIPS_RF_WRITE_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 4; k++) begin
            step();
            check("cont_wen", bus.rf_wen, 1);
            check("cont_wa", bus.rf_wa, 5);
            check("cont_wd", bus.rf_wd, 32'hA);
            check("cont_rdy", bus.req_ready, 3'b001);
        end
`else
        step();
        check("cont_wa1", bus.rf_wa, 5); check("cont_wd1", bus.rf_wd, 32'hA);
        check("cont_wen1", bus.rf_wen, 1); check("cont_rdy1", bus.req_ready, 3'b010);
        step();
        check("cont_wa2", bus.rf_wa, 6); check("cont_wd2", bus.rf_wd, 32'hB);
        check("cont_wen2", bus.rf_wen, 1); check("cont_rdy2", bus.req_ready, 3'b100);
        step();
        check("cont_wa3", bus.rf_wa, 7); check("cont_wd3", bus.rf_wd, 32'hC);
        check("cont_wen3", bus.rf_wen, 1); check("cont_rdy3", bus.req_ready, 3'b001);
        step();
        check("cont_wa4", bus.rf_wa, 5); check("cont_wen4", bus.rf_wen, 1);
`endif
        bus.req_valid = '0;
        #1;
        check("idle_rdy", bus.req_ready, 0);
        step();
        check("idle_wen", bus.rf_wen, 0);
        check("idle_wa_hold", bus.rf_wa, 5);
        check("idle_wd_hold", bus.rf_wd, 32'hA);

        // Scoreboard lifecycle on reg 9
        rsv_en = 1'b1; rsv_addr = 5'd9; chk_ra1 = 5'd9;
        #1;
        check("sb_no_bypass", busy1, 0);
        step();
        rsv_en = 1'b0;
        check("sb_busy1", busy1, 1);
        check("sb_stall", stall, 1);
        bus.req_valid = 3'b010; set_req(1, 5'd9, 32'h1234);
        #1;
        check("sb_rdy", bus.req_ready, 3'b010);
        step();
        bus.req_valid = '0;
        check("sb_wen", bus.rf_wen, 1);
        check("sb_wa", bus.rf_wa, 9);
        check("sb_wd", bus.rf_wd, 32'h1234);
        check("sb_busy1_clr", busy1, 0);
        check("sb_stall_clr", stall, 0);

        // Address 0: reserve and write are both ignored by the scoreboard
        rsv_en = 1'b1; rsv_addr = 5'd0; chk_ra1 = 5'd0;
        bus.req_valid = 3'b100; set_req(2, 5'd0, 32'h5555);
        #1;
        check("a0_rdy", bus.req_ready, 3'b100);
        step();
        rsv_en = 1'b0;
        bus.req_valid = 3'b110; set_req(1, 5'd20, 32'h20);
        check("a0_wen", bus.rf_wen, 0);
        check("a0_busy1", busy1, 0);
        check("a0_err", rsv_err, 0);
        // Pointer moved to 2, so requester 1 wins over 2
        #1;
        check("a0_ptr_rdy", bus.req_ready, 3'b010);
        step();
        bus.req_valid = '0;
        check("a0_next_wa", bus.rf_wa, 20);
        check("a0_next_wen", bus.rf_wen, 1);

        // Set/clear collision on reg 4
        rsv_en = 1'b1; rsv_addr = 5'd4; chk_ra2 = 5'd4;
        step();
        check("col_busy_pre", busy2, 1);
        bus.req_valid = 3'b001; set_req(0, 5'd4, 32'h44);
        step();
        rsv_en = 1'b0;
        bus.req_valid = '0;
        check("col_wen", bus.rf_wen, 1);
        check("col_wa", bus.rf_wa, 4);
        check("col_busy", busy2, 1);
        check("col_err", rsv_err, 0);
        bus.req_valid = 3'b001;
        step();
        bus.req_valid = '0;
        check("col_busy_clr", busy2, 0);

        // Double reserve of reg 12
        rsv_en = 1'b1; rsv_addr = 5'd12; chk_ra1 = 5'd12;
        step();
        check("dbl_err_first", rsv_err, 0);
        step();
        rsv_en = 1'b0;
        check("dbl_err", rsv_err, 1);
        bus.req_valid = 3'b001; set_req(0, 5'd12, 32'hC12);
        step();
        bus.req_valid = '0;
        check("dbl_wa", bus.rf_wa, 12);
        check("dbl_busy_clr", busy1, 0);
        step();
        check("dbl_err_sticky", rsv_err, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_rf_write_arbiter.md
Name: mips_rf_write_arbiter

Overview:
- Shares the single write port of the MIPS register file between NREQ writeback sources, e.g. ALU, load unit and multi-cycle MUL/DIV.
- Uses a round-robin valid/ready arbiter and registers the winning write onto the register file write port.
- Holds a per-register scoreboard: issue logic reserves a destination register, the committed write releases it, and operand lookups return busy/stall.
- Sits between the execute/memory stages and the register file write port (wen/WA/WD).

Parameters:
- AWL, 5, register address width (2**AWL registers).
- DWL, 32, register data width.
- NREQ, 3, number of write requesters (2..8).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  requester i has a write pending.
- req_ready  out  NREQ  grant to requester i; combinational, one-hot or zero.
- req_wa  in  NREQ*AWL  write address, requester i in bits [i*AWL +: AWL].
- req_wd  in  NREQ*DWL  write data, requester i in bits [i*DWL +: DWL].
- rsv_en  in  1  reserve destination register rsv_addr.
- rsv_addr  in  AWL  register to reserve.
- chk_ra1  in  AWL  operand 1 address to check.
- chk_ra2  in  AWL  operand 2 address to check.
- busy1  out  1  chk_ra1 has a pending write.
- busy2  out  1  chk_ra2 has a pending write.
- stall  out  1  busy1 | busy2.
- rsv_err  out  1  sticky: a register was reserved while already busy.
- rf_wen  out  1  register file write enable (registered).
- rf_wa  out  AWL  register file write address (registered).
- rf_wd  out  DWL  register file write data (registered).

Behaviour:
- Reset, asynchronous on rst_n low:
  - rf_wen=0, rf_wa=0, rf_wd=0, rsv_err=0.
  - All scoreboard bits cleared.
  - Round-robin pointer last=NREQ-1, so requester 0 has first priority.
- Arbitration, combinational each cycle:
  - Search for valid requesters starting at (last+1) mod NREQ, wrapping.
  - The first valid requester found gets req_ready=1; all others get 0.
  - No valid requester: req_ready all 0.
- Transfer: req_valid[i] & req_ready[i].
  - On the next edge, last<=i, rf_wa<=req_wa[i], rf_wd<=req_wd[i].
  - rf_wen<=1 only if req_wa[i]!=0.
  - No transfer: rf_wen<=0; last, rf_wa and rf_wd hold.
- Latency: exactly one cycle from accepted request to rf_wen. Throughput: one write per cycle.
- Address 0 write:
  - The handshake completes normally and the pointer advances.
  - rf_wen stays 0 and no scoreboard change occurs.
- Requesters hold valid, wa and wd stable until ready. The arbiter never drops a valid request.
- Scoreboard busy[2**AWL-1:1]; register 0 is never busy.
  - Set: rsv_en & rsv_addr!=0 sets busy[rsv_addr] at the edge.
  - Clear: a transfer to wa!=0 clears busy[wa] at the same edge that loads rf_wen.
  - Set and clear on the same address in the same cycle: set wins (new reservation survives).
  - rsv_en to an address already busy, with no same-cycle clear: bit stays set, rsv_err<=1 and stays 1 until reset.
- Lookup, combinational from registered state:
  - busy1 = busy[chk_ra1] & (chk_ra1!=0); busy2 likewise; stall = busy1|busy2.
  - No bypass of same-cycle set or clear.
- Reset mid-operation discards in-flight writes and all reservations. rf_wen drops immediately.

Optional Feature:
- Macro MIPS_RF_WRITE_ARB_FIXED_PRIO_EN.
  - Defined: fixed priority, lowest index wins. The pointer is not implemented.
  - Undefined: round-robin as above.
- All other behaviour, including latency, the address-0 rule and the scoreboard, is identical in both builds.

Test Plan:
- Reset: assert rst_n=0 mid-cycle. Required: rf_wen=0, stall=0, rsv_err=0 with no clock edge.
- Contention: req_valid=3'b111 held, wa=5/6/7, wd=A/B/C.
  - Round-robin: grants 0,1,2,0. rf_wen every cycle with wa 5,6,7,5, each one cycle after its grant.
  - Fixed priority (macro defined): requester 0 granted every cycle.
- Scoreboard lifecycle:
  - rsv_en on reg 9, then chk_ra1=9: busy1=1, stall=1.
  - Requester 1 writes wa=9, wd=32'h1234 and is granted. Next cycle: rf_wen=1, wa=9, wd=32'h1234, busy1=0.
- Address 0: rsv_en with rsv_addr=0, then requester 2 writes wa=0.
  - Handshake completes, rf_wen stays 0.
  - chk_ra1=0 gives busy1=0. rsv_err stays 0.
- Set/clear collision: reg 4 busy; in the same cycle, a transfer to wa=4 and rsv_en on 4. Required: busy[4]=1 afterwards, rsv_err=0.
- Double reserve: rsv_en on 12 twice with no write between. Required: rsv_err=1 and it stays 1 after reg 12 is written.
